// File: rtl/slatch_pkg.sv
// Shared types and defaults for the slatch_req latch-port requester.
//   state_e      : handshake FSM states (idle, request held, release wait)
//   DefDepth     : default pending-bit FIFO depth
//   DefTmoCycles : default ack-wait timeout in clk cycles
package slatch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRel
  } state_e;

  localparam int unsigned DefDepth     = 4;
  localparam int unsigned DefTmoCycles = 15;

endpackage

// File: rtl/slatch_fifo.sv
// 1-bit synchronous FIFO holding bits waiting to be sent to the latch port.
// Ports:
//   clk   : clock, rising edge
//   res   : synchronous active-high reset, empties the FIFO
//   push  : write wd (ignored while full, even with a pop at the same edge)
//   wd    : bit to write
//   pop   : discard head entry (ignored while empty)
//   rd    : head entry
//   full  : DEPTH entries held
//   empty : no entries held
module slatch_fifo
  import slatch_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic clk,
  input  logic res,
  input  logic push,
  input  logic wd,
  input  logic pop,
  output logic rd,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign rd    = mem_q[rptr_q];

  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (do_push) begin
      mem_d[wptr_q] = wd;
      wptr_d        = wptr_q + AW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    // DEPTH is a power of two, so pointers wrap naturally.
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/slatch_req.sv
// Four-phase requester: queues single bits and hands them one at a time to a
// latch port using a req/ack return-to-zero handshake.
// Optional feature macro: SLATCH_REQ_TIMEOUT_EN -- abandons a handshake after
// TMO_CYCLES cycles in REQ/REL, pulsing err and dropping the in-flight bit.
// Ports:
//   clk  : clock, rising edge
//   res  : synchronous active-high reset
//   wr   : push request for wd
//   wd   : bit to push
//   full : FIFO holds DEPTH entries
//   busy : FIFO non-empty or handshake in progress
//   req  : four-phase request to the latch port
//   d    : data presented with req
//   ack  : four-phase acknowledge from the latch port
//   err  : one-cycle timeout pulse (constant 0 without the timeout feature)
module slatch_req
  import slatch_pkg::*;
#(
  parameter int unsigned DEPTH      = DefDepth,
  parameter int unsigned TMO_CYCLES = DefTmoCycles
) (
  input  logic clk,
  input  logic res,
  input  logic wr,
  input  logic wd,
  output logic full,
  output logic busy,
  output logic req,
  output logic d,
  input  logic ack,
  output logic err
);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("slatch_req: DEPTH must be a power of two in 2..16");
  end
  if (TMO_CYCLES < 1) begin : g_bad_tmo
    $error("slatch_req: TMO_CYCLES must be at least 1");
  end

  state_e state_q, state_d;
  logic   req_q, req_d;
  logic   d_q, d_d;
  logic   pop, head, empty;

  slatch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .res  (res),
    .push (wr),
    .wd   (wd),
    .pop  (pop),
    .rd   (head),
    .full (full),
    .empty(empty)
  );

`ifdef SLATCH_REQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TMO_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    d_d     = d_q;
    pop     = 1'b0;
`ifdef SLATCH_REQ_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        // ack still high means the responder has not released yet; wait.
        if (!empty && !ack) begin
          pop     = 1'b1;
          d_d     = head;
          req_d   = 1'b1;
          state_d = StReq;
`ifdef SLATCH_REQ_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      StReq: begin
        if (ack) begin
          req_d   = 1'b0;
          state_d = StRel;
`ifdef SLATCH_REQ_TIMEOUT_EN
          tmo_d   = '0;
        end else begin
          tmo_d   = tmo_q + TW'(1);
`endif
        end
      end
      StRel: begin
        if (!ack) begin
          state_d = StIdle;
`ifdef SLATCH_REQ_TIMEOUT_EN
        end else begin
          tmo_d   = tmo_q + TW'(1);
`endif
        end
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
`ifdef SLATCH_REQ_TIMEOUT_EN
    // Timeout only fires when the handshake made no progress this cycle.
    if (state_q != StIdle && state_d == state_q && tmo_q == TW'(TMO_CYCLES - 1)) begin
      req_d   = 1'b0;
      err_d   = 1'b1;
      state_d = StIdle;
      tmo_d   = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      d_q     <= 1'b0;
`ifdef SLATCH_REQ_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      d_q     <= d_d;
`ifdef SLATCH_REQ_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  assign req  = req_q;
  assign d    = d_q;
  assign busy = !empty || (state_q != StIdle);
`ifdef SLATCH_REQ_TIMEOUT_EN
  assign err  = err_q;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_slatch_req.sv
module tb_slatch_req;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 15;

  logic clk, res, wr, wd, ack;
  logic full, busy, req, d, err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bits expected at the latch, bits seen there, FIFO fill.
  bit exp_q[$];
  bit rx_q[$];
  int occ;

  slatch_req #(
    .DEPTH     (DEPTH),
    .TMO_CYCLES(TMO)
  ) dut (
    .clk (clk),
    .res (res),
    .wr  (wr),
    .wd  (wd),
    .full(full),
    .busy(busy),
    .req (req),
    .d   (d),
    .ack (ack),
    .err (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_reset(input bit ack_val);
    res = 1'b1;
    wr  = 1'b0;
    ack = ack_val;
    @(negedge clk);
    res = 1'b0;
    occ = 0;
    exp_q.delete();
    rx_q.delete();
  endtask

  // One wr cycle; the model accepts it only when the FIFO has room.
  task automatic push_bit(input bit b, input string name);
    wr = 1'b1;
    wd = b;
    @(negedge clk);
    wr = 1'b0;
    if (occ < int'(DEPTH)) begin
      occ++;
      exp_q.push_back(b);
    end
    n_tests++;
    if (full !== (occ == int'(DEPTH))) begin
      n_fail++;
      $display("FAIL %s_full: got %b expected %b (occ %0d)", name, full, occ == int'(DEPTH), occ);
    end
  endtask

  // Latch-port responder with random ack delay; records each delivered bit,
  // checks d stays stable while req is high, and finally checks order.
  task automatic drain(input int max_dly, input string name);
    bit seen = 1'b0;
    bit cap  = 1'b0;
    bit done = 1'b0;
    bit ok;
    int wait_cnt = 0;
    int got_v = 0;
    int exp_v = 0;
    for (int c = 0; c < 600 && !done; c++) begin
      @(negedge clk);
      n_tests++;
      if (err !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_err: got %b expected 0", name, err);
      end
      if (req) begin
        if (!seen) begin
          seen     = 1'b1;
          cap      = d;
          rx_q.push_back(d);
          wait_cnt = int'($urandom_range(max_dly, 0));
        end else begin
          n_tests++;
          if (d !== cap) begin
            n_fail++;
            $display("FAIL %s_d_stable: got %b expected %b", name, d, cap);
          end
        end
        if (!ack) begin
          if (wait_cnt == 0) ack = 1'b1;
          else wait_cnt--;
        end
      end else begin
        ack  = 1'b0;
        seen = 1'b0;
        if (!busy) done = 1'b1;
      end
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_drain_timeout: busy=%b req=%b expected idle", name, busy, req);
    end
    ok = (rx_q.size() == exp_q.size());
    foreach (exp_q[i]) exp_v = (exp_v << 1) | int'(exp_q[i]);
    foreach (rx_q[i]) got_v = (got_v << 1) | int'(rx_q[i]);
    if (ok) foreach (exp_q[i]) if (rx_q[i] !== exp_q[i]) ok = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_order: got %0d bits 'b%0b expected %0d bits 'b%0b", name,
               rx_q.size(), got_v, exp_q.size(), exp_v);
    end
    rx_q.delete();
    exp_q.delete();
    occ = 0;
  endtask

  task automatic test_reset;
    res = 1'b1; wr = 1'b0; wd = 1'b0; ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({req, d, err, full, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset: got req,d,err,full,busy=%b expected 00000",
               {req, d, err, full, busy});
    end
    res = 1'b0;
  endtask

  task automatic test_single;
    do_reset(1'b0);
    wr = 1'b1; wd = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    n_tests++;
    if (req !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_push: got req=%b busy=%b expected req=0 busy=1", req, busy);
    end
    @(negedge clk);
    n_tests++;
    if (req !== 1'b1 || d !== 1'b1) begin
      n_fail++;
      $display("FAIL single_rise: got req=%b d=%b expected req=1 d=1", req, d);
    end
    @(negedge clk);
    n_tests++;
    if (req !== 1'b1) begin
      n_fail++;
      $display("FAIL single_hold: got req=%b expected 1", req);
    end
    ack = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_fall: got req=%b busy=%b expected req=0 busy=1", req, busy);
    end
    ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_fill;
    bit pat[4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) push_bit(pat[i], "fill");
    push_bit(1'b0, "fill_extra");
    ack = 1'b0;
    drain(3, "fill");
  endtask

  task automatic test_ack_held;
    do_reset(1'b1);
    push_bit(1'b1, "ackheld");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (req !== 1'b0) begin
        n_fail++;
        $display("FAIL ackheld_wait: got req=%b expected 0 (cycle %0d)", req, i);
      end
    end
    ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req !== 1'b1 || d !== 1'b1) begin
      n_fail++;
      $display("FAIL ackheld_rise: got req=%b d=%b expected req=1 d=1", req, d);
    end
    drain(2, "ackheld");
  endtask

  task automatic test_push_pop;
    do_reset(1'b1);
    push_bit(1'b1, "pushpop");
    push_bit(1'b0, "pushpop");
    // Same edge: head popped into the handshake, new bit pushed; fill stays 2.
    ack = 1'b0; wr = 1'b1; wd = 1'b0;
    @(negedge clk);
    wr = 1'b0;
    exp_q.push_back(1'b0);
    n_tests++;
    if (req !== 1'b1 || d !== 1'b1 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL pushpop_edge: got req=%b d=%b full=%b expected 1 1 0", req, d, full);
    end
    push_bit(1'b1, "pushpop3");
    push_bit(1'b1, "pushpop4");
    drain(3, "pushpop");
  endtask

  task automatic test_reset_mid;
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) push_bit(1'($urandom), "resmid");
    ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if (req !== 1'b1) begin
      n_fail++;
      $display("FAIL resmid_req: got req=%b expected 1", req);
    end
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    n_tests++;
    if (req !== 1'b0 || busy !== 1'b0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL resmid_after: got req=%b busy=%b full=%b expected 0 0 0", req, busy, full);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if (req !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL resmid_quiet: got req=%b busy=%b expected 0 0 (cycle %0d)", req, busy, i);
      end
    end
    exp_q.delete();
    occ = 0;
  endtask

  task automatic test_random;
    int n;
    do_reset(1'b0);
    for (int it = 0; it < 10; it++) begin
      ack = 1'b1;
      n = int'($urandom_range(DEPTH + 2, 1));
      for (int i = 0; i < n; i++) push_bit(1'($urandom), "random");
      n_tests++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL random_busy: got %b expected 1 (iter %0d)", busy, it);
      end
      ack = 1'b0;
      drain(4, "random");
    end
  endtask

`ifdef SLATCH_REQ_TIMEOUT_EN
  task automatic test_timeout;
    do_reset(1'b0);
    wr = 1'b1; wd = 1'b1;
    @(negedge clk);
    wd = 1'b0;
    @(negedge clk);
    wr = 1'b0;
    // req rose at the last edge; the first bit will be abandoned.
    exp_q.push_back(1'b0);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == TMO - 1) begin
        n_tests++;
        if (req !== 1'b1 || err !== 1'b0) begin
          n_fail++;
          $display("FAIL tmo_before: got req=%b err=%b expected 1 0", req, err);
        end
      end
      if (k == TMO) begin
        n_tests++;
        if (req !== 1'b0 || err !== 1'b1) begin
          n_fail++;
          $display("FAIL tmo_fire: got req=%b err=%b expected 0 1", req, err);
        end
      end
      if (k == TMO + 1) begin
        n_tests++;
        if (req !== 1'b1 || err !== 1'b0 || d !== 1'b0) begin
          n_fail++;
          $display("FAIL tmo_next: got req=%b err=%b d=%b expected 1 0 0", req, err, d);
        end
      end
    end
    drain(3, "tmo");
  endtask
`else
  task automatic test_no_timeout;
    int bad = 0;
    do_reset(1'b0);
    push_bit(1'b1, "notmo");
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req !== 1'b1 || err !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL notmo_wait: got %0d cycles with req!=1 or err!=0 expected 0", bad);
    end
    drain(2, "notmo");
  endtask
`endif

  initial begin
    occ = 0;
    test_reset();
    test_single();
    test_fill();
    test_ack_held();
    test_push_pop();
    test_reset_mid();
    test_random();
`ifdef SLATCH_REQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/slatch_req.md
SLATCH_REQ -- requirements
Module: slatch_req

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of pending-bit FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 Parameter TMO_CYCLES, default 15, SHALL set the ack-wait timeout in clk cycles; it is used only when SLATCH_REQ_TIMEOUT_EN is defined.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port res, input, 1 bit, SHALL be the reset: synchronous, active-high.
REQ-005 Port wr, input, 1 bit, SHALL request a push of wd into the FIFO.
REQ-006 Port wd, input, 1 bit, SHALL carry the bit value to be pushed.
REQ-007 Port full, output, 1 bit, SHALL be high when the FIFO holds DEPTH entries.
REQ-008 Port busy, output, 1 bit, SHALL be high when the FIFO is non-empty or the state machine is not IDLE.
REQ-009 Port req, output, 1 bit, SHALL be the four-phase request to the latch port.
REQ-010 Port d, output, 1 bit, SHALL be the data presented with req.
REQ-011 Port ack, input, 1 bit, SHALL be the four-phase acknowledge from the latch port.
REQ-012 Port err, output, 1 bit, SHALL be the one-cycle timeout pulse.

Function
REQ-013 A push SHALL occur when wr=1 and full=0 at the clock edge; a wr while full=1 SHALL be ignored with no state change, even if a pop occurs at the same edge.
REQ-014 A simultaneous push and pop SHALL leave the entry count unchanged and preserve FIFO order.
REQ-015 The state machine SHALL have exactly three states: IDLE, REQ and REL.
REQ-016 In IDLE, when the FIFO is non-empty and ack=0, the block SHALL pop the head into d, set req=1 and go to REQ at the same edge.
REQ-017 In IDLE with ack=1, the block SHALL wait and SHALL NOT pop.
REQ-018 The first req rise SHALL come one edge after the push edge of an empty, idle block (latency 1 cycle).
REQ-019 In REQ, req and d SHALL be held stable until ack is sampled as 1; then req<=0 and the state goes to REL.
REQ-020 In REL, the block SHALL wait for ack sampled as 0, then go to IDLE; the next transfer may start no earlier than the following edge.
REQ-021 The handshake SHALL tolerate any number of ack-delay cycles, including when the responder grants another requester first.
REQ-022 d SHALL change only on the edge that raises req.
REQ-023 Without SLATCH_REQ_TIMEOUT_EN, err SHALL be constant 0.

Reset
REQ-024 When res=1, the block SHALL empty the FIFO and set state=IDLE, req=0, d=0, err=0 and the timeout counter to 0; consequently full=0 and busy=0.
REQ-025 Reset asserted mid-handshake SHALL drop req at that edge and discard the in-flight bit.
REQ-026 After reset, the block SHALL NOT assert req until ack has been sampled as 0 (per REQ-017).

Configuration
REQ-027 With SLATCH_REQ_TIMEOUT_EN defined, a counter SHALL clear on entry to REQ or REL and increment each cycle spent in those states.
REQ-028 With SLATCH_REQ_TIMEOUT_EN defined, when the counter reaches TMO_CYCLES the block SHALL set req<=0, pulse err=1 for one cycle, go to IDLE and drop the in-flight bit.
REQ-029 Without SLATCH_REQ_TIMEOUT_EN, no counter logic SHALL exist and the block SHALL wait indefinitely.

Structure
REQ-030 Package slatch_pkg SHALL hold the state enum (IDLE, REQ, REL) and the DEPTH and TMO_CYCLES default constants.
REQ-031 The FIFO SHALL be the sub-module slatch_fifo: a 1-bit synchronous FIFO with push, pop, full and empty, reset by res.

Verification
REQ-032 Push wd=1 with ack tied to the responder acking 2 cycles later -> req rises 1 cycle after the push with d=1, falls 1 cycle after ack=1, and busy=0 after ack falls.
REQ-033 Push 1,0,1,1 back-to-back -> full=1 after the 4th push; a 5th wr is ignored; the latch sees 1,0,1,1 in order.
REQ-034 Hold ack=1 from reset, then push -> req stays 0 until ack=0, then rises.
REQ-035 Assert res while in REQ with 2 entries queued -> req=0 and busy=0 at the next edge, and no further requests occur.
REQ-036 With SLATCH_REQ_TIMEOUT_EN defined and ack stuck at 0 -> req drops and err=1 for one cycle exactly TMO_CYCLES (15) cycles after req rose; the next entry then proceeds.
REQ-037 Push and pop at the same edge while the FIFO holds 2 entries -> count stays 2 and order is preserved.
